branch_predictor: RTL and testbench

//  Fetch-side counterpart to the ID-stage branch compare unit. It predicts

---
 rtl/branch_predictor_if.sv | 33 +++
 rtl/branch_predictor.sv | 108 ++++++++++
 tb/tb_branch_predictor.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Fetch-lookup and ID-resolution bundle between the fetch unit and the branch predictor.
interface branch_predictor_if #(
  parameter int unsigned CNT_BITS = 16
);
  logic [31:0]         fetch_pc;
  logic                pred_taken;
  logic [31:0]         pred_target;
  logic                res_valid;
  logic                res_is_branch;
  logic [31:0]         res_pc;
  logic                res_taken;
  logic [31:0]         res_target;
  logic                res_pred_taken;
  logic [31:0]         res_pred_target;
  logic                mispredict;
  logic [31:0]         redirect_pc;
  logic [CNT_BITS-1:0] br_count;
  logic [CNT_BITS-1:0] mis_count;

  // Fetch/ID side: supplies PCs and resolutions, consumes predictions.
  modport master (
    output fetch_pc, res_valid, res_is_branch, res_pc, res_taken, res_target,
           res_pred_taken, res_pred_target,
    input  pred_taken, pred_target, mispredict, redirect_pc, br_count, mis_count
  );

  // Predictor side.
  modport slave (
    input  fetch_pc, res_valid, res_is_branch, res_pc, res_taken, res_target,
           res_pred_taken, res_pred_target,
    output pred_taken, pred_target, mispredict, redirect_pc, br_count, mis_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters; trained from ID-stage
// resolutions, flags mispredicts and supplies the fetch redirect PC.
module branch_predictor #(
  parameter int unsigned IDX_BITS = 6,
  parameter int unsigned TAG_BITS = 8,
  parameter int unsigned CNT_BITS = 16
) (
  input logic               CLK,
  input logic               RESET,
  branch_predictor_if.slave bp
);

  localparam int unsigned ENTRIES = 1 << IDX_BITS;
  localparam int unsigned TAG_LO  = IDX_BITS + 2;
  localparam int unsigned TAG_HI  = IDX_BITS + TAG_BITS + 1;

  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];

  logic [CNT_BITS-1:0] br_q;
  logic [CNT_BITS-1:0] mis_q;

  logic [IDX_BITS-1:0] f_idx;
  logic [TAG_BITS-1:0] f_tag;
  logic [IDX_BITS-1:0] r_idx;
  logic [TAG_BITS-1:0] r_tag;
  logic                f_hit;
  logic                r_hit;
  logic                update;
  logic                target_mismatch;

  // PC bits outside the index/tag fields never participate in the lookup.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bp.fetch_pc[31:TAG_HI+1], bp.fetch_pc[1:0],
                            bp.res_pc[31:TAG_HI+1], bp.res_pc[1:0]};

  assign f_idx  = bp.fetch_pc[IDX_BITS+1:2];
  assign f_tag  = bp.fetch_pc[TAG_HI:TAG_LO];
  assign r_idx  = bp.res_pc[IDX_BITS+1:2];
  assign r_tag  = bp.res_pc[TAG_HI:TAG_LO];
  assign update = bp.res_valid & bp.res_is_branch;

  // Fetch lookup; reads pre-update contents and is forced to a miss during reset.
  always_comb begin
    f_hit          = 1'b0;
    bp.pred_taken  = 1'b0;
    bp.pred_target = 32'd0;
    if (RESET) begin
      f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
      if (f_hit) begin
        bp.pred_taken  = ctr_q[f_idx][1];
        bp.pred_target = target_q[f_idx];
      end
    end
  end

  // Resolution compare and redirect; the not-taken path skips the delay slot.
  always_comb begin
    r_hit           = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
    target_mismatch = bp.res_taken & bp.res_pred_taken &
                      (bp.res_target != bp.res_pred_target);
    bp.mispredict   = update & ((bp.res_taken != bp.res_pred_taken) | target_mismatch);
    bp.redirect_pc  = bp.res_taken ? bp.res_target : bp.res_pc + 32'd8;
  end

  // Table training: counter update on hit, allocate on taken miss.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 32'd0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (update) begin
      if (r_hit) begin
        if (bp.res_taken) begin
          target_q[r_idx] <= bp.res_target;
          if (ctr_q[r_idx] != 2'b11) ctr_q[r_idx] <= ctr_q[r_idx] + 2'd1;
        end else if (ctr_q[r_idx] != 2'b00) begin
          ctr_q[r_idx] <= ctr_q[r_idx] - 2'd1;
        end
      end else if (bp.res_taken) begin
        valid_q[r_idx]  <= 1'b1;
        tag_q[r_idx]    <= r_tag;
        target_q[r_idx] <= bp.res_target;
        ctr_q[r_idx]    <= 2'b10;
      end
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      br_q  <= '0;
      mis_q <= '0;
    end else if (update) begin
      if (br_q != {CNT_BITS{1'b1}}) br_q <= br_q + CNT_BITS'(1);
      if (bp.mispredict && (mis_q != {CNT_BITS{1'b1}})) mis_q <= mis_q + CNT_BITS'(1);
    end
  end

  assign bp.br_count  = br_q;
  assign bp.mis_count = mis_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: allocation, counter training,
// aliasing, same-cycle lookup, redirect wrap, async reset and count saturation.
module tb_branch_predictor;

  logic CLK;
  logic RESET;
  int   checks;
  int   errors;

  branch_predictor_if #(.CNT_BITS(16)) bus ();
  branch_predictor_if #(.CNT_BITS(4))  sbus ();

  branch_predictor #(.IDX_BITS(6), .TAG_BITS(8), .CNT_BITS(16)) dut (
    .CLK(CLK), .RESET(RESET), .bp(bus)
  );

  branch_predictor #(.IDX_BITS(6), .TAG_BITS(8), .CNT_BITS(4)) dut_small (
    .CLK(CLK), .RESET(RESET), .bp(sbus)
  );

  typedef struct {
    logic        t;
    logic        pt;
    logic [31:0] ptg;
    logic [31:0] tgt;
    logic        mis;
    logic [31:0] redir;
    logic        pred;
    logic [31:0] ptgt;
    logic [15:0] br;
    logic [15:0] mc;
  } row_t;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Advance to one time unit after the next rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_res(input logic v, input logic b, input logic [31:0] pc,
                           input logic t, input logic [31:0] tgt,
                           input logic pt, input logic [31:0] ptg);
    bus.res_valid       = v;
    bus.res_is_branch   = b;
    bus.res_pc          = pc;
    bus.res_taken       = t;
    bus.res_target      = tgt;
    bus.res_pred_taken  = pt;
    bus.res_pred_target = ptg;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    bus.fetch_pc = 32'h0040_0010;
    drive_res(1'b1, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 32'd0);
    sbus.fetch_pc = 32'd0; sbus.res_valid = 1'b0; sbus.res_is_branch = 1'b0;
    sbus.res_pc = 32'd0; sbus.res_taken = 1'b0; sbus.res_target = 32'd0;
    sbus.res_pred_taken = 1'b0; sbus.res_pred_target = 32'd0;
    #2;
    checks++; if (bus.pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred_taken: got %b expected 0", bus.pred_taken); end
    checks++; if (bus.pred_target !== 32'd0) begin errors++; $display("FAIL reset_pred_target: got %h expected 0", bus.pred_target); end
    checks++; if (bus.mispredict !== 1'b1) begin errors++; $display("FAIL reset_mispredict_follows: got %b expected 1", bus.mispredict); end
    step(); step();
    checks++; if (bus.br_count !== 16'd0) begin errors++; $display("FAIL reset_br_count: got %h expected 0", bus.br_count); end
    checks++; if (bus.mis_count !== 16'd0) begin errors++; $display("FAIL reset_mis_count: got %h expected 0", bus.mis_count); end
    checks++; if (bus.pred_taken !== 1'b0) begin errors++; $display("FAIL reset_no_alloc: got %b expected 0", bus.pred_taken); end
    #2;
    RESET = 1'b1;
    drive_res(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic test_allocate();
    step();
    bus.fetch_pc = 32'h0040_0010;
    drive_res(1'b1, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 32'd0);
    #1;
    checks++; if (bus.mispredict !== 1'b1) begin errors++; $display("FAIL alloc_mispredict: got %b expected 1", bus.mispredict); end
    checks++; if (bus.redirect_pc !== 32'h0040_0100) begin errors++; $display("FAIL alloc_redirect: got %h expected 00400100", bus.redirect_pc); end
    step();
    drive_res(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    #1;
    checks++; if (bus.pred_taken !== 1'b1) begin errors++; $display("FAIL alloc_pred_taken: got %b expected 1", bus.pred_taken); end
    checks++; if (bus.pred_target !== 32'h0040_0100) begin errors++; $display("FAIL alloc_pred_target: got %h expected 00400100", bus.pred_target); end
    checks++; if (bus.mis_count !== 16'd1) begin errors++; $display("FAIL alloc_mis_count: got %h expected 1", bus.mis_count); end
    checks++; if (bus.br_count !== 16'd1) begin errors++; $display("FAIL alloc_br_count: got %h expected 1", bus.br_count); end
  endtask

  task automatic test_train();
    row_t rows[10];
    rows[0] = '{1'b0, 1'b1, 32'h0040_0100, 32'h0040_0100, 1'b1, 32'h0040_0018, 1'b0, 32'h0040_0100, 16'd2,  16'd2};
    rows[1] = '{1'b0, 1'b0, 32'h0040_0100, 32'h0040_0100, 1'b0, 32'h0040_0018, 1'b0, 32'h0040_0100, 16'd3,  16'd2};
    rows[2] = '{1'b0, 1'b0, 32'h0040_0100, 32'h0040_0100, 1'b0, 32'h0040_0018, 1'b0, 32'h0040_0100, 16'd4,  16'd2};
    rows[3] = '{1'b0, 1'b0, 32'h0040_0100, 32'h0040_0100, 1'b0, 32'h0040_0018, 1'b0, 32'h0040_0100, 16'd5,  16'd2};
    rows[4] = '{1'b1, 1'b0, 32'h0040_0100, 32'h0040_0100, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0100, 16'd6,  16'd3};
    rows[5] = '{1'b1, 1'b0, 32'h0040_0100, 32'h0040_0100, 1'b1, 32'h0040_0100, 1'b1, 32'h0040_0100, 16'd7,  16'd4};
    rows[6] = '{1'b1, 1'b1, 32'h0040_0100, 32'h0040_0100, 1'b0, 32'h0040_0100, 1'b1, 32'h0040_0100, 16'd8,  16'd4};
    rows[7] = '{1'b1, 1'b1, 32'h0040_0100, 32'h0040_0100, 1'b0, 32'h0040_0100, 1'b1, 32'h0040_0100, 16'd9,  16'd4};
    rows[8] = '{1'b0, 1'b1, 32'h0040_0100, 32'h0040_0100, 1'b1, 32'h0040_0018, 1'b1, 32'h0040_0100, 16'd10, 16'd5};
    rows[9] = '{1'b1, 1'b1, 32'h0040_0200, 32'h0040_0300, 1'b1, 32'h0040_0300, 1'b1, 32'h0040_0300, 16'd11, 16'd6};
    bus.fetch_pc = 32'h0040_0010;
    for (int i = 0; i < 10; i++) begin
      drive_res(1'b1, 1'b1, 32'h0040_0010, rows[i].t, rows[i].tgt, rows[i].pt, rows[i].ptg);
      #1;
      checks++; if (bus.mispredict !== rows[i].mis) begin errors++; $display("FAIL train_mispredict[%0d]: got %b expected %b", i, bus.mispredict, rows[i].mis); end
      checks++; if (bus.redirect_pc !== rows[i].redir) begin errors++; $display("FAIL train_redirect[%0d]: got %h expected %h", i, bus.redirect_pc, rows[i].redir); end
      step();
      checks++; if (bus.pred_taken !== rows[i].pred) begin errors++; $display("FAIL train_pred_taken[%0d]: got %b expected %b", i, bus.pred_taken, rows[i].pred); end
      checks++; if (bus.pred_target !== rows[i].ptgt) begin errors++; $display("FAIL train_pred_target[%0d]: got %h expected %h", i, bus.pred_target, rows[i].ptgt); end
      checks++; if (bus.br_count !== rows[i].br) begin errors++; $display("FAIL train_br_count[%0d]: got %h expected %h", i, bus.br_count, rows[i].br); end
      checks++; if (bus.mis_count !== rows[i].mc) begin errors++; $display("FAIL train_mis_count[%0d]: got %h expected %h", i, bus.mis_count, rows[i].mc); end
    end
    drive_res(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic test_alias();
    // 0x00400110 shares index 4 with 0x00400010 but carries tag 0x01.
    drive_res(1'b1, 1'b1, 32'h0040_0110, 1'b1, 32'h0050_0000, 1'b0, 32'd0);
    #1;
    checks++; if (bus.mispredict !== 1'b1) begin errors++; $display("FAIL alias_mispredict: got %b expected 1", bus.mispredict); end
    step();
    drive_res(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    bus.fetch_pc = 32'h0040_0010;
    #1;
    checks++; if (bus.pred_taken !== 1'b0) begin errors++; $display("FAIL alias_old_taken: got %b expected 0", bus.pred_taken); end
    checks++; if (bus.pred_target !== 32'd0) begin errors++; $display("FAIL alias_old_target: got %h expected 0", bus.pred_target); end
    bus.fetch_pc = 32'h0040_0110;
    #1;
    checks++; if (bus.pred_taken !== 1'b1) begin errors++; $display("FAIL alias_new_taken: got %b expected 1", bus.pred_taken); end
    checks++; if (bus.pred_target !== 32'h0050_0000) begin errors++; $display("FAIL alias_new_target: got %h expected 00500000", bus.pred_target); end
    // Fresh entry starts at ctr=2: a single not-taken drops prediction.
    drive_res(1'b1, 1'b1, 32'h0040_0110, 1'b0, 32'd0, 1'b1, 32'h0050_0000);
    #1;
    checks++; if (bus.redirect_pc !== 32'h0040_0118) begin errors++; $display("FAIL alias_nt_redirect: got %h expected 00400118", bus.redirect_pc); end
    step();
    drive_res(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    #1;
    checks++; if (bus.pred_taken !== 1'b0) begin errors++; $display("FAIL alias_ctr2: got %b expected 0", bus.pred_taken); end
    checks++; if (bus.pred_target !== 32'h0050_0000) begin errors++; $display("FAIL alias_hit_target: got %h expected 00500000", bus.pred_target); end
    // Not-taken miss never allocates.
    bus.fetch_pc = 32'h0040_0040;
    drive_res(1'b1, 1'b1, 32'h0040_0040, 1'b0, 32'h0060_0000, 1'b0, 32'd0);
    #1;
    checks++; if (bus.mispredict !== 1'b0) begin errors++; $display("FAIL miss_nt_mispredict: got %b expected 0", bus.mispredict); end
    step();
    drive_res(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    #1;
    checks++; if (bus.pred_target !== 32'd0) begin errors++; $display("FAIL miss_nt_no_alloc: got %h expected 0", bus.pred_target); end
    checks++; if (bus.br_count !== 16'd14 || bus.mis_count !== 16'd8) begin errors++; $display("FAIL alias_counts: got %0d/%0d expected 14/8", bus.br_count, bus.mis_count); end
  endtask

  task automatic test_same_cycle();
    step();
    bus.fetch_pc = 32'h0040_0020;
    drive_res(1'b1, 1'b1, 32'h0040_0020, 1'b1, 32'h0040_0400, 1'b0, 32'd0);
    #1;
    checks++; if (bus.pred_taken !== 1'b0) begin errors++; $display("FAIL same_cycle_pre: got %b expected 0", bus.pred_taken); end
    step();
    drive_res(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    #1;
    checks++; if (bus.pred_taken !== 1'b1) begin errors++; $display("FAIL same_cycle_post: got %b expected 1", bus.pred_taken); end
    checks++; if (bus.pred_target !== 32'h0040_0400) begin errors++; $display("FAIL same_cycle_target: got %h expected 00400400", bus.pred_target); end
  endtask

  task automatic test_no_update();
    drive_res(1'b0, 1'b1, 32'h0040_0020, 1'b1, 32'h0070_0000, 1'b0, 32'd0);
    #1;
    checks++; if (bus.mispredict !== 1'b0) begin errors++; $display("FAIL novalid_mispredict: got %b expected 0", bus.mispredict); end
    step();
    drive_res(1'b1, 1'b0, 32'h0040_0020, 1'b1, 32'h0070_0000, 1'b0, 32'd0);
    #1;
    checks++; if (bus.mispredict !== 1'b0) begin errors++; $display("FAIL nobranch_mispredict: got %b expected 0", bus.mispredict); end
    step();
    drive_res(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    #1;
    checks++; if (bus.br_count !== 16'd15 || bus.mis_count !== 16'd9) begin errors++; $display("FAIL no_update_counts: got %0d/%0d expected 15/9", bus.br_count, bus.mis_count); end
    checks++; if (bus.pred_target !== 32'h0040_0400) begin errors++; $display("FAIL no_update_target: got %h expected 00400400", bus.pred_target); end
  endtask

  task automatic test_redirect_wrap();
    drive_res(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0, 1'b1, 32'h0000_1234);
    #1;
    checks++; if (bus.redirect_pc !== 32'h0000_0004) begin errors++; $display("FAIL wrap_redirect: got %h expected 00000004", bus.redirect_pc); end
    checks++; if (bus.mispredict !== 1'b1) begin errors++; $display("FAIL wrap_mispredict: got %b expected 1", bus.mispredict); end
    step();
    drive_res(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    #1;
    checks++; if (bus.br_count !== 16'd16 || bus.mis_count !== 16'd10) begin errors++; $display("FAIL wrap_counts: got %0d/%0d expected 16/10", bus.br_count, bus.mis_count); end
  endtask

  task automatic test_async_reset();
    step();
    bus.fetch_pc = 32'h0040_0020;
    drive_res(1'b1, 1'b1, 32'h0040_0020, 1'b1, 32'h0040_0800, 1'b0, 32'd0);
    #2;
    RESET = 1'b0;
    #1;
    checks++; if (bus.pred_taken !== 1'b0 || bus.pred_target !== 32'd0) begin errors++; $display("FAIL async_pred: got %b/%h expected 0/0", bus.pred_taken, bus.pred_target); end
    checks++; if (bus.br_count !== 16'd0 || bus.mis_count !== 16'd0) begin errors++; $display("FAIL async_counts: got %0d/%0d expected 0/0", bus.br_count, bus.mis_count); end
    checks++; if (bus.mispredict !== 1'b1) begin errors++; $display("FAIL async_mispredict: got %b expected 1", bus.mispredict); end
    step();
    checks++; if (bus.br_count !== 16'd0) begin errors++; $display("FAIL async_held_br: got %0d expected 0", bus.br_count); end
    #2;
    RESET = 1'b1;
    drive_res(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    step();
    checks++; if (bus.pred_taken !== 1'b0 || bus.pred_target !== 32'd0) begin errors++; $display("FAIL async_cleared_0020: got %b/%h expected 0/0", bus.pred_taken, bus.pred_target); end
    bus.fetch_pc = 32'h0040_0110;
    #1;
    checks++; if (bus.pred_target !== 32'd0) begin errors++; $display("FAIL async_cleared_0110: got %h expected 0", bus.pred_target); end
  endtask

  task automatic test_saturate();
    step();
    sbus.res_valid = 1'b1; sbus.res_is_branch = 1'b1; sbus.res_pc = 32'h0000_0100;
    sbus.res_taken = 1'b1; sbus.res_target = 32'h0000_0200; sbus.res_pred_taken = 1'b0;
    for (int i = 0; i < 15; i++) step();
    checks++; if (sbus.br_count !== 4'hF || sbus.mis_count !== 4'hF) begin errors++; $display("FAIL sat_reach: got %h/%h expected f/f", sbus.br_count, sbus.mis_count); end
    for (int i = 0; i < 5; i++) step();
    checks++; if (sbus.br_count !== 4'hF || sbus.mis_count !== 4'hF) begin errors++; $display("FAIL sat_hold: got %h/%h expected f/f", sbus.br_count, sbus.mis_count); end
    #2;
    RESET = 1'b0;
    #1;
    checks++; if (sbus.br_count !== 4'h0 || sbus.mis_count !== 4'h0) begin errors++; $display("FAIL sat_reset: got %h/%h expected 0/0", sbus.br_count, sbus.mis_count); end
    sbus.res_valid = 1'b0;
    step();
    RESET = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_allocate();
    test_train();
    test_alias();
    test_same_cycle();
    test_no_update();
    test_redirect_wrap();
    test_async_reset();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
